// File: rtl/lcd_timing_writer_if.sv
// Pixel FIFO read port between the FIFO (slave) and the LCD timing writer (master).
// rgb is the FIFO read data; it is valid the cycle after data_req.
interface lcd_timing_writer_if;
  logic [23:0] rgb;
  logic        data_valid;
  logic        data_req;

  modport master (output data_req, input rgb, input data_valid);
  modport slave  (input data_req, output rgb, output data_valid);
endinterface

// File: rtl/lcd_timing_writer.sv
// Parallel RGB LCD timing generator: free-running H/V counters, one FIFO pop per fed
// active pixel, fill colour on underrun, two-stage output pipeline aligned with FIFO data.
module lcd_timing_writer #(
  parameter int          H_ACTIVE   = 480,
  parameter int          H_PULSE    = 41,
  parameter int          H_BP       = 2,
  parameter int          H_FP       = 2,
  parameter int          V_ACTIVE   = 272,
  parameter int          V_PULSE    = 10,
  parameter int          V_BP       = 2,
  parameter int          V_FP       = 2,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic                 clk_12mhz,
  input  logic                 rst,
  lcd_timing_writer_if.master  fifo,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [23:0]          lcd_rgb,
  output logic                 lcd_dclk,
  output logic                 lcd_disp_en,
  output logic                 lcd_hsync,
  output logic                 lcd_vsync,
  output logic                 lcd_de
);

  localparam int H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC    = HW'(H_PULSE);
  localparam logic [HW-1:0] H_ACT_BEG = HW'(H_PULSE + H_BP);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_PULSE + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC    = VW'(V_PULSE);
  localparam logic [VW-1:0] V_ACT_BEG = VW'(V_PULSE + V_BP);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_PULSE + V_BP + V_ACTIVE);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          active;
  logic          pixel_fed;
  logic          pixel_starved;
  logic          at_origin;

  logic          s1_hsync_reg;
  logic          s1_vsync_reg;
  logic          s1_de_reg;
  logic          s1_fed_reg;
  logic          underrun_reg;
  logic          disp_en_reg;
  logic [23:0]   pixel_next;

  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  assign active = (h_cnt_reg >= H_ACT_BEG) && (h_cnt_reg < H_ACT_END) &&
                  (v_cnt_reg >= V_ACT_BEG) && (v_cnt_reg < V_ACT_END);
  assign pixel_fed     = active & fifo.data_valid;
  assign pixel_starved = active & ~fifo.data_valid;
  assign at_origin     = (h_cnt_reg == '0) && (v_cnt_reg == '0);

  // Counters sit at the origin while reset is held, so the strobes are gated by rst too.
  assign fifo.data_req = pixel_fed & rst;
  assign frame_start   = at_origin & rst;
  assign underrun      = underrun_reg;
  assign lcd_disp_en   = disp_en_reg;
  assign lcd_dclk      = ~clk_12mhz;

  // Stage 1: timing flags delayed to line up with the FIFO read data.
  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      s1_hsync_reg <= 1'b1;
      s1_vsync_reg <= 1'b1;
      s1_de_reg    <= 1'b0;
      s1_fed_reg   <= 1'b0;
    end else begin
      s1_hsync_reg <= (h_cnt_reg >= H_SYNC);
      s1_vsync_reg <= (v_cnt_reg >= V_SYNC);
      s1_de_reg    <= active;
      s1_fed_reg   <= pixel_fed;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign pixel_next[gi*8 +: 8] = !s1_de_reg ? 8'h00 :
                                     s1_fed_reg ? fifo.rgb[gi*8 +: 8] :
                                                  FILL_COLOR[gi*8 +: 8];
    end
  endgenerate

  // Stage 2: registered panel outputs.
  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
      lcd_de    <= 1'b0;
      lcd_rgb   <= '0;
    end else begin
      lcd_hsync <= s1_hsync_reg;
      lcd_vsync <= s1_vsync_reg;
      lcd_de    <= s1_de_reg;
      lcd_rgb   <= pixel_next;
    end
  end

  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      underrun_reg <= 1'b0;
      disp_en_reg  <= 1'b0;
    end else begin
      if (at_origin) begin
        underrun_reg <= 1'b0;
      end else if (pixel_starved) begin
        underrun_reg <= 1'b1;
      end
      if (at_origin) begin
        disp_en_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_writer.sv
// Checks lcd_timing_writer against a position-arithmetic model (default timing, random
// FIFO availability, mid-line reset) and a tiny-parameter instance for frame wrap counts.
module tb_lcd_timing_writer;

  localparam int HT   = 525;
  localparam int VT   = 286;
  localparam int FT   = HT * VT;
  localparam int HA0  = 43;
  localparam int HA1  = 523;
  localparam int VA0  = 12;
  localparam int VA1  = 284;
  localparam logic [23:0] FILL = 24'h000000;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } px_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic rst_b = 1'b0;
  bit   phase2 = 1'b0;

  lcd_timing_writer_if fa();
  lcd_timing_writer_if fb();

  logic        fs_a, und_a, dclk_a, den_a, hs_a, vs_a, de_a;
  logic [23:0] rgb_a;
  logic        fs_b, und_b, dclk_b, den_b, hs_b, vs_b, de_b;
  logic [23:0] rgb_b;

  lcd_timing_writer dut_a (
    .clk_12mhz(clk), .rst(rst_n), .fifo(fa),
    .frame_start(fs_a), .underrun(und_a), .lcd_rgb(rgb_a), .lcd_dclk(dclk_a),
    .lcd_disp_en(den_a), .lcd_hsync(hs_a), .lcd_vsync(vs_a), .lcd_de(de_a)
  );

  lcd_timing_writer #(
    .H_ACTIVE(4), .H_PULSE(1), .H_BP(1), .H_FP(1),
    .V_ACTIVE(2), .V_PULSE(1), .V_BP(1), .V_FP(1)
  ) dut_b (
    .clk_12mhz(clk), .rst(rst_b), .fifo(fb),
    .frame_start(fs_b), .underrun(und_b), .lcd_rgb(rgb_b), .lcd_dclk(dclk_b),
    .lcd_disp_en(den_b), .lcd_hsync(hs_b), .lcd_vsync(vs_b), .lcd_de(de_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", nm, t, act, exp);
    end
  endtask

  // Cycle index since the latest reset release; cycle 0 runs until the first rising edge.
  int t;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) t <= 0;
    else        t <= t + 1;

  // FIFO models: an endless incrementing word stream that is never flushed.
  logic [23:0] word_a = 24'd1;
  logic [23:0] word_b = 24'd1;
  initial begin
    fa.rgb = '0;
    fb.rgb = '0;
  end
  always @(posedge clk) begin
    if (fa.data_req) begin
      fa.rgb <= word_a;
      word_a <= word_a + 24'd1;
    end
    if (fb.data_req) begin
      fb.rgb <= word_b;
      word_b <= word_b + 24'd1;
    end
  end

  function automatic bit act_at(input int c);
    int h = c % HT;
    int v = (c / HT) % VT;
    return (h >= HA0) && (h < HA1) && (v >= VA0) && (v < VA1);
  endfunction

  function automatic bit dv_rule(input int c);
    if (!phase2 && c >= 6400 && c <= 6404) return 1'b0;
    if (!phase2 && c < 7000) return 1'b1;
    return ($urandom_range(0, 99) < 85);
  endfunction

  px_t         q[$];
  logic [23:0] m_word = 24'd1;
  bit          m_und  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_und = 1'b0;
    end else begin
      bit  a;
      bit  dv;
      px_t cur;
      px_t e;
      a  = act_at(t);
      dv = fa.data_valid;
      chk("data_req", {31'd0, fa.data_req}, {31'd0, a && dv});
      chk("frame_start", {31'd0, fs_a}, {31'd0, (t % FT) == 0});
      chk("underrun", {31'd0, und_a}, {31'd0, m_und});
      chk("disp_en", {31'd0, den_a}, {31'd0, t >= 1});
      chk("dclk", {31'd0, dclk_a}, 32'd1);
      if (q.size() == 2) begin
        e = q.pop_front();
        chk("hsync", {31'd0, hs_a}, {31'd0, e.hs});
        chk("vsync", {31'd0, vs_a}, {31'd0, e.vs});
        chk("de", {31'd0, de_a}, {31'd0, e.de});
        chk("rgb", {8'd0, rgb_a}, {8'd0, e.rgb});
      end else begin
        chk("hsync_pre", {31'd0, hs_a}, 32'd1);
        chk("vsync_pre", {31'd0, vs_a}, 32'd1);
        chk("de_pre", {31'd0, de_a}, 32'd0);
        chk("rgb_pre", {8'd0, rgb_a}, 32'd0);
      end
      cur.hs  = (t % HT) >= 41;
      cur.vs  = ((t / HT) % VT) >= 10;
      cur.de  = a;
      cur.rgb = (a && dv) ? m_word : (a ? FILL : 24'd0);
      q.push_back(cur);
      if (a && dv) m_word = m_word + 24'd1;
      if ((t % FT) == 0)  m_und = 1'b0;
      else if (a && !dv)  m_und = 1'b1;
      // Hand-computed anchors for the first frame after power-up.
      if (!phase2) begin
        if (t == 42)   chk("pin_hsync_low", {31'd0, hs_a}, 32'd0);
        if (t == 43)   chk("pin_hsync_high", {31'd0, hs_a}, 32'd1);
        if (t == 6344) chk("pin_de_before", {31'd0, de_a}, 32'd0);
        if (t == 6345) chk("pin_first_pixel", {8'd0, rgb_a}, 32'd1);
        if (t == 6345) chk("pin_de_first", {31'd0, de_a}, 32'd1);
        if (t == 6346) chk("pin_second_pixel", {8'd0, rgb_a}, 32'd2);
        if (t == 6400) chk("pin_und_clear", {31'd0, und_a}, 32'd0);
        if (t == 6401) chk("pin_last_fed", {8'd0, rgb_a}, 32'd57);
        if (t == 6402) chk("pin_fill_de", {31'd0, de_a}, 32'd1);
        if (t == 6402) chk("pin_fill_rgb", {8'd0, rgb_a}, {8'd0, FILL});
        if (t == 6406) chk("pin_und_set", {31'd0, und_a}, 32'd1);
        if (t == 6407) chk("pin_resume", {8'd0, rgb_a}, 32'd58);
      end
    end
  end

  int b_cyc     = 0;
  int b_last_fs = -1;
  int b_reqs    = 0;
  int b_des     = 0;
  always @(negedge clk) begin
    if (rst_b) begin
      if (fs_b) begin
        if (b_last_fs >= 0) begin
          chk("b_period", b_cyc - b_last_fs, 32'd35);
          chk("b_reqs", b_reqs, 32'd8);
          chk("b_de_cycles", b_des, 32'd8);
        end
        b_last_fs = b_cyc;
        b_reqs    = 0;
        b_des     = 0;
      end
      if (fb.data_req) b_reqs++;
      if (de_b)        b_des++;
      chk("b_disp_en", {31'd0, den_b}, {31'd0, b_cyc >= 1});
      chk("b_underrun", {31'd0, und_b}, 32'd0);
      b_cyc++;
    end
  end

  initial begin
    fa.data_valid = 1'b1;
    fb.data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    rst_b = 1'b1;
    repeat (8000) begin
      @(posedge clk);
      #1 fa.data_valid = dv_rule(t);
    end
    // Asynchronous reset mid-active line, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hsync", {31'd0, hs_a}, 32'd1);
    chk("rst_vsync", {31'd0, vs_a}, 32'd1);
    chk("rst_de", {31'd0, de_a}, 32'd0);
    chk("rst_rgb", {8'd0, rgb_a}, 32'd0);
    chk("rst_disp_en", {31'd0, den_a}, 32'd0);
    chk("rst_req", {31'd0, fa.data_req}, 32'd0);
    chk("rst_fs", {31'd0, fs_a}, 32'd0);
    chk("rst_und", {31'd0, und_a}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    phase2 = 1'b1;
    rst_n  = 1'b1;
    #1 chk("fs_after_rst", {31'd0, fs_a}, 32'd1);
    repeat (10500) begin
      @(posedge clk);
      #1 fa.data_valid = dv_rule(t);
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
